// File: rtl/ternary_operand_loader.sv
// Serial-to-parallel loader: gathers two N-trit operands one trit per beat and holds them in two-rail form.
// Optional invalid-trit scrubbing and sticky error flag enabled by defining TERNARY_TRIT_CHECK_EN.
module ternary_operand_loader #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_t0,
   input  logic         in_t1,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] a0,
   output logic [N-1:0] a1,
   output logic [N-1:0] b0,
   output logic [N-1:0] b1,
   output logic         err
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      FILL_A,
      FILL_B,
      HOLD
   } stateT;

   stateT         state;
   logic [CW-1:0] cnt;
   logic          beat;
   logic          storeT0;
   logic          storeT1;

   // A beat offered in a clear cycle is discarded, never stored.
   assign beat = in_valid & in_ready & ~clr;

`ifdef TERNARY_TRIT_CHECK_EN
   logic badTrit;
   logic errReg;

   assign badTrit = in_t0 & in_t1;
   assign storeT0 = in_t0 & ~badTrit;
   assign storeT1 = in_t1 & ~badTrit;
   assign err     = errReg;

   // Sticky flag: any accepted 11 trit latches it until clear or reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         errReg <= 1'b0;
      end else if (clr) begin
         errReg <= 1'b0;
      end else if (beat && badTrit) begin
         errReg <= 1'b1;
      end
   end
`else
   assign storeT0 = in_t0;
   assign storeT1 = in_t1;
   assign err     = 1'b0;
`endif

   // Fill A, fill B, then hold both operands until the consumer handshakes.
   // in_ready and out_valid are registered alongside the state so they never glitch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= FILL_A;
         cnt       <= '0;
         a0        <= '0;
         a1        <= '0;
         b0        <= '0;
         b1        <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else if (clr) begin
         state     <= FILL_A;
         cnt       <= '0;
         a0        <= '0;
         a1        <= '0;
         b0        <= '0;
         b1        <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state)
            FILL_A: begin
               if (beat) begin
                  a0[cnt] <= storeT0;
                  a1[cnt] <= storeT1;
                  if (cnt == LAST) begin
                     cnt   <= '0;
                     state <= FILL_B;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            FILL_B: begin
               if (beat) begin
                  b0[cnt] <= storeT0;
                  b1[cnt] <= storeT1;
                  if (cnt == LAST) begin
                     cnt       <= '0;
                     state     <= HOLD;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            HOLD: begin
               // Operand rails are left untouched; the next fill overwrites them trit by trit.
               if (out_ready) begin
                  state     <= FILL_A;
                  cnt       <= '0;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= FILL_A;
               cnt       <= '0;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ternary_operand_loader.sv
// Randomised self-checking bench for ternary_operand_loader against a trit-array reference model.
// Expected invalid-trit behaviour follows whether TERNARY_TRIT_CHECK_EN is defined.
`timescale 1ns/1ps
module tb_ternary_operand_loader;

   localparam int N = 4;
`ifdef TERNARY_TRIT_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         clr;
   logic         in_valid;
   logic         in_ready;
   logic         in_t0;
   logic         in_t1;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] a0;
   logic [N-1:0] a1;
   logic [N-1:0] b0;
   logic [N-1:0] b1;
   logic         err;

   int compared   = 0;
   int mismatched = 0;

   // Reference model: operand contents as trit values (3 stands for the 11 pattern)
   int modelA[N];
   int modelB[N];
   bit modelErr;

   ternary_operand_loader #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready), .in_t0(in_t0), .in_t1(in_t1),
      .out_valid(out_valid), .out_ready(out_ready),
      .a0(a0), .a1(a1), .b0(b0), .b1(b1), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] encode(input int v);
      case (v)
         1:       return 2'b01;
         2:       return 2'b10;
         3:       return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   // Expected {a1,a0,b1,b0}; an invalid trit reads back as 0 when checking is enabled
   function automatic logic [4*N-1:0] expRails();
      logic [N-1:0] ea0, ea1, eb0, eb1;
      logic [1:0]   s;
      for (int i = 0; i < N; i++) begin
         s = (modelA[i] == 3 && CHECK_EN) ? 2'b00 : encode(modelA[i]);
         ea1[i] = s[1];
         ea0[i] = s[0];
         s = (modelB[i] == 3 && CHECK_EN) ? 2'b00 : encode(modelB[i]);
         eb1[i] = s[1];
         eb0[i] = s[0];
      end
      return {ea1, ea0, eb1, eb0};
   endfunction

   function automatic void clearModel();
      for (int i = 0; i < N; i++) begin
         modelA[i] = 0;
         modelB[i] = 0;
      end
      modelErr = 1'b0;
   endfunction

   function automatic void randomModel(input bit allowBad);
      for (int i = 0; i < N; i++) begin
         modelA[i] = (allowBad && $urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2));
         modelB[i] = (allowBad && $urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2));
      end
   endfunction

   // Offer one trit after 'gap' idle cycles; returns just after the accepting edge
   task automatic sendTrit(input int v, input int gap);
      int waited;
      if (gap > 0) begin
         @(negedge clk);
         in_valid = 1'b0;
         repeat (gap - 1) @(negedge clk);
      end
      @(negedge clk);
      in_valid = 1'b1;
      {in_t1, in_t0} = encode(v);
      waited = 0;
      while (in_ready !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 20) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL beat_timeout in_ready=%b required 1", in_ready);
      end
      if (v == 3 && CHECK_EN) modelErr = 1'b1;
      @(posedge clk);
   endtask

   // Send A then B from the model; ends on the negedge after the last beat with in_valid low
   task automatic loadPair(input int gapMax, input bit toggle, input bit randReady);
      for (int i = 0; i < 2 * N; i++) begin
         if (randReady) out_ready = 1'($urandom_range(0, 1));
         sendTrit((i < N) ? modelA[i] : modelB[i - N],
                  toggle ? 1 : int'($urandom_range(0, gapMax)));
      end
      @(negedge clk);
      in_valid = 1'b0;
      if (randReady) out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_t0 = 1'b0; in_t1 = 1'b0; out_ready = 1'b0;
      clearModel();
      #12;
      compared++;
      if ({out_valid, a1, a0, b1, b0, err} !== '0) begin
         mismatched++;
         $display("[TB] FAIL reset_outputs got %b required all zero", {out_valid, a1, a0, b1, b0, err});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      compared++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_release in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_basic();
      modelA = '{2, 1, 0, 1};
      modelB = '{1, 1, 2, 0};
      out_ready = 1'b1;
      loadPair(0, 1'b0, 1'b0);
      compared++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL basic_hold out_valid=%b in_ready=%b required 1/0", out_valid, in_ready);
      end
      compared++;
      if ({a1, a0, b1, b0} !== {4'b0001, 4'b1010, 4'b0100, 4'b0011}) begin
         mismatched++;
         $display("[TB] FAIL basic_rails got %b required %b", {a1, a0, b1, b0},
                  {4'b0001, 4'b1010, 4'b0100, 4'b0011});
      end
      @(negedge clk);
      compared++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL basic_single_cycle out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_hold_backpressure();
      logic [4*N-1:0] exp;
      randomModel(1'b0);
      out_ready = 1'b0;
      loadPair(0, 1'b0, 1'b0);
      exp = expRails();
      // Keep offering trits during HOLD; none of them may be taken
      for (int c = 0; c < 5; c++) begin
         compared++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || {a1, a0, b1, b0} !== exp) begin
            mismatched++;
            $display("[TB] FAIL hold_stable cyc=%0d got v=%b r=%b rails=%h required 1/0/%h",
                     c, out_valid, in_ready, {a1, a0, b1, b0}, exp);
         end
         in_valid = 1'b1;
         {in_t1, in_t0} = encode(int'($urandom_range(1, 2)));
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b0;
      compared++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || {a1, a0, b1, b0} !== exp) begin
         mismatched++;
         $display("[TB] FAIL hold_release got v=%b r=%b rails=%h required 0/1/%h",
                  out_valid, in_ready, {a1, a0, b1, b0}, exp);
      end
   endtask

   task automatic test_toggle();
      modelA = '{2, 1, 0, 1};
      modelB = '{1, 1, 2, 0};
      out_ready = 1'b0;
      loadPair(0, 1'b1, 1'b0);
      compared++;
      if (out_valid !== 1'b1 || {a1, a0, b1, b0} !== {4'b0001, 4'b1010, 4'b0100, 4'b0011}) begin
         mismatched++;
         $display("[TB] FAIL toggle_rails got v=%b rails=%b required 1/%b", out_valid, {a1, a0, b1, b0},
                  {4'b0001, 4'b1010, 4'b0100, 4'b0011});
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_clr();
      randomModel(1'b0);
      out_ready = 1'b0;
      for (int i = 0; i < N; i++) sendTrit(modelA[i], 0);
      sendTrit(modelB[0], 0);
      @(negedge clk);
      clr = 1'b1;
      in_valid = 1'b1;
      {in_t1, in_t0} = encode(2);
      @(negedge clk);
      clr = 1'b0;
      in_valid = 1'b0;
      clearModel();
      compared++;
      if ({a1, a0, b1, b0} !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL clr_state got rails=%h v=%b r=%b e=%b required 0/0/1/0",
                  {a1, a0, b1, b0}, out_valid, in_ready, err);
      end
      randomModel(1'b0);
      loadPair(1, 1'b0, 1'b0);
      compared++;
      if (out_valid !== 1'b1 || {a1, a0, b1, b0} !== expRails()) begin
         mismatched++;
         $display("[TB] FAIL clr_reload got v=%b rails=%h required 1/%h", out_valid, {a1, a0, b1, b0}, expRails());
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      randomModel(1'b0);
      modelA[0] = 2;
      out_ready = 1'b0;
      loadPair(0, 1'b0, 1'b0);
      compared++;
      if (out_valid !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL areset_pre out_valid=%b required 1", out_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      clearModel();
      compared++;
      if (out_valid !== 1'b0 || {a1, a0, b1, b0} !== '0 || err !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL areset_immediate got v=%b rails=%h e=%b required 0/0/0",
                  out_valid, {a1, a0, b1, b0}, err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      compared++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL areset_release in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_invalid_trit();
      modelA = '{1, 2, 3, 0};
      modelB = '{2, 0, 1, 1};
      out_ready = 1'b0;
      loadPair(0, 1'b0, 1'b0);
      compared++;
      if (a1[2] !== !CHECK_EN || a0[2] !== !CHECK_EN || err !== CHECK_EN) begin
         mismatched++;
         $display("[TB] FAIL invalid_trit got a1[2]=%b a0[2]=%b err=%b required %b/%b/%b",
                  a1[2], a0[2], err, !CHECK_EN, !CHECK_EN, CHECK_EN);
      end
      compared++;
      if ({a1, a0, b1, b0} !== expRails()) begin
         mismatched++;
         $display("[TB] FAIL invalid_rails got %h required %h", {a1, a0, b1, b0}, expRails());
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      compared++;
      if (err !== modelErr) begin
         mismatched++;
         $display("[TB] FAIL invalid_sticky err=%b required %b", err, modelErr);
      end
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      clearModel();
      compared++;
      if (err !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL invalid_clr err=%b required 0", err);
      end
   endtask

   task automatic test_random();
      int delay;
      for (int it = 0; it < 20; it++) begin
         randomModel(1'b1);
         loadPair(2, 1'b0, 1'b1);
         compared++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || {a1, a0, b1, b0} !== expRails() || err !== modelErr) begin
            mismatched++;
            $display("[TB] FAIL random_hold it=%0d got v=%b r=%b rails=%h e=%b required 1/0/%h/%b",
                     it, out_valid, in_ready, {a1, a0, b1, b0}, err, expRails(), modelErr);
         end
         delay = int'($urandom_range(0, 3));
         for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            compared++;
            if (out_valid !== 1'b1 || {a1, a0, b1, b0} !== expRails()) begin
               mismatched++;
               $display("[TB] FAIL random_wait it=%0d got v=%b rails=%h required 1/%h",
                        it, out_valid, {a1, a0, b1, b0}, expRails());
            end
         end
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         compared++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL random_handshake it=%0d got v=%b r=%b required 0/1", it, out_valid, in_ready);
         end
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_basic();
      test_hold_backpressure();
      test_toggle();
      test_clr();
      test_async_reset();
      test_invalid_trit();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
